// File: rtl/issue_pkg.sv
// Shared types and constants for the dual-slot ID-stage issue controller.
package issue_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    LU_WAIT = 2'd1,
    SPLIT   = 2'd2
  } issue_state_e;

  localparam logic [4:0] REG_X0 = 5'd0;

endpackage

// File: rtl/dual_issue_ctrl_sat_counter.sv
// Saturating event counter: increments on inc_i, holds at all-ones, cleared by rst.
module sat_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_q <= cnt_q + W'(1);
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/dual_issue_ctrl.sv
// ID-stage issue controller: issues the decoded pair together, splits on intra-pair
// dependences, and inserts load-use bubbles; outputs are combinational from state + inputs.
module dual_issue_ctrl
  import issue_pkg::*;
#(
  parameter int unsigned LU_BUBBLES = 1,
  parameter int unsigned CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             ex_hold,
  input  logic             id_valid,
  output logic             id_ready,
  input  logic [4:0]       s0_rd,
  input  logic             s0_rd_we,
  input  logic             s0_haz_rs1,
  input  logic             s0_haz_rs2,
  input  logic             s0_ld_rs1,
  input  logic             s0_ld_rs2,
  input  logic             s1_valid,
  input  logic [4:0]       s1_rs1,
  input  logic [4:0]       s1_rs2,
  input  logic             s1_use_rs1,
  input  logic             s1_use_rs2,
  input  logic             s1_haz_rs1,
  input  logic             s1_haz_rs2,
  input  logic             s1_ld_rs1,
  input  logic             s1_ld_rs2,
  output logic             issue0,
  output logic             issue1,
  output logic [1:0]       fwd0,
  output logic [1:0]       fwd1,
  output logic [CNT_W-1:0] lu_stall_cnt,
  output logic [CNT_W-1:0] split_cnt,
  output logic [1:0]       state_o
);

  localparam int unsigned BUB_W = 3;
  localparam logic [BUB_W-1:0] BUB_RELOAD = BUB_W'(LU_BUBBLES - 1);

  issue_state_e     state_q, state_d;
  logic [BUB_W-1:0] bub_q, bub_d;
  logic             ret_split_q, ret_split_d;
  logic             lu0, lu1, dep;
  logic             inc_lu, inc_split;

  assign lu0 = (s0_haz_rs1 & s0_ld_rs1) | (s0_haz_rs2 & s0_ld_rs2);
  assign lu1 = (s1_haz_rs1 & s1_ld_rs1) | (s1_haz_rs2 & s1_ld_rs2);
  assign dep = s1_valid & s0_rd_we & (s0_rd != REG_X0) &
               ((s1_use_rs1 & (s1_rs1 == s0_rd)) | (s1_use_rs2 & (s1_rs2 == s0_rd)));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      bub_q       <= '0;
      ret_split_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bub_q       <= bub_d;
      ret_split_q <= ret_split_d;
    end
  end

  // Issue decision and next state; priority rst > flush > ex_hold > FSM.
  always_comb begin
    issue0      = 1'b0;
    issue1      = 1'b0;
    id_ready    = 1'b0;
    inc_lu      = 1'b0;
    inc_split   = 1'b0;
    state_d     = state_q;
    bub_d       = bub_q;
    ret_split_d = ret_split_q;
    if (rst) begin
      state_d = RUN;
    end else if (flush) begin
      id_ready = 1'b1;
      state_d  = RUN;
      bub_d    = '0;
    end else if (!ex_hold) begin
      unique case (state_q)
        RUN: begin
          if (!id_valid) begin
            id_ready = 1'b1;
          end else if (lu0) begin
            inc_lu = 1'b1;
            bub_d  = BUB_RELOAD;
            if (BUB_RELOAD != '0) begin
              state_d     = LU_WAIT;
              ret_split_d = 1'b0;
            end
          end else if (s1_valid && (dep || lu1)) begin
            issue0    = 1'b1;
            inc_split = 1'b1;
            state_d   = SPLIT;
          end else begin
            issue0   = 1'b1;
            issue1   = s1_valid;
            id_ready = 1'b1;
          end
        end
        LU_WAIT: begin
          inc_lu = 1'b1;
          bub_d  = bub_q - BUB_W'(1);
          if (bub_q == BUB_W'(1)) begin
            state_d = ret_split_q ? SPLIT : RUN;
          end
        end
        SPLIT: begin
          if (lu1) begin
            inc_lu = 1'b1;
            bub_d  = BUB_RELOAD;
            if (BUB_RELOAD != '0) begin
              state_d     = LU_WAIT;
              ret_split_d = 1'b1;
            end
          end else begin
            issue1   = 1'b1;
            id_ready = 1'b1;
            state_d  = RUN;
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

  assign fwd0 = {s0_haz_rs2 & ~s0_ld_rs2, s0_haz_rs1 & ~s0_ld_rs1} & {2{issue0}};
  assign fwd1 = {s1_haz_rs2 & ~s1_ld_rs2, s1_haz_rs1 & ~s1_ld_rs1} & {2{issue1}};
  assign state_o = state_q;

  sat_counter #(.W(CNT_W)) u_lu_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc_i (inc_lu),
    .cnt_o (lu_stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_split_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc_i (inc_split),
    .cnt_o (split_cnt)
  );

endmodule
